// File: rtl/hsi_rx_pkg.sv
// rtl/hsi_rx_pkg.sv - shared types, parity modes and helpers for the HSI frame receiver
// HSI_RX_MAJORITY_EN selects 2-of-3 majority sampling (one extra tick of decision delay).
package hsi_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

`ifdef HSI_RX_MAJORITY_EN
  localparam int MAJ_DELAY = 1;
`else
  localparam int MAJ_DELAY = 0;
`endif

  // Expected parity bit; zero-extension of data does not change the result.
  function automatic logic par_calc(input logic [15:0] data, input int mode);
    if (mode == PAR_ODD) return ~^data;
    return ^data;
  endfunction

endpackage

// File: rtl/hsi_rx_bit_timer.sv
// rtl/hsi_rx_bit_timer.sv - oversampling tick counter and data bit index for the HSI receiver
// HSI_RX_MAJORITY_EN moves the start-bit decision one tick later via MAJ_DELAY.
module hsi_rx_bit_timer
  import hsi_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OSR    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         restart,
  input  logic                         in_start,
  output logic                         mid,
  output logic                         last_bit,
  output logic [$clog2(DATA_W+1)-1:0]  bit_idx
);

  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] BIT_END   = TW'(OSR - 1);
  localparam logic [TW-1:0] START_END = TW'(OSR / 2 - 1 + MAJ_DELAY);

  logic [TW-1:0] tick_cnt;

  // The start bit is checked half a bit in; every later bit is a full bit period apart.
  assign mid      = clk_en && (tick_cnt == (in_start ? START_END : BIT_END));
  assign last_bit = (bit_idx == BW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_idx  <= '0;
    end else if (clk_en) begin
      if (restart) begin
        tick_cnt <= '0;
        bit_idx  <= '0;
      end else if (mid) begin
        tick_cnt <= '0;
        bit_idx  <= bit_idx + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hsi_frame_rx.sv
// rtl/hsi_frame_rx.sv - HSI serial frame receiver with parity/framing checks and message-end detect
// HSI_RX_MAJORITY_EN: every sample point is a 2-of-3 majority decided one tick after mid-bit.
module hsi_frame_rx
  import hsi_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OSR       = 8,
  parameter int PARITY    = 1,
  parameter int MSB_FIRST = 0,
  parameter int MSG_GAP   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              d,
  output logic [DATA_W-1:0] q,
  output logic              q_rdy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic              msg_end
);

  localparam int BW = $clog2(DATA_W + 1);

  rx_state_t         state, state_nxt;
  logic              mid, last_bit, tmr_restart, s;
  logic [BW-1:0]     bit_idx, pos;
  logic [DATA_W-1:0] stage;
  logic              par_ok, gap_armed;
  logic [7:0]        gap_cnt;

`ifdef HSI_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b11;
    else if (clk_en) hist <= {hist[0], d};
  end

  assign s = (hist[1] & hist[0]) | (hist[1] & d) | (hist[0] & d);
`else
  assign s = d;
`endif

  hsi_rx_bit_timer #(
    .DATA_W (DATA_W),
    .OSR    (OSR)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .restart  (tmr_restart),
    .in_start (state == S_START),
    .mid      (mid),
    .last_bit (last_bit),
    .bit_idx  (bit_idx)
  );

  assign pos  = (MSB_FIRST != 0) ? BW'(DATA_W - 1) - bit_idx : bit_idx;
  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt   = state;
    tmr_restart = 1'b0;
    case (state)
      S_IDLE: begin
        tmr_restart = 1'b1;
        if (clk_en && !d) state_nxt = S_START;
      end
      S_START: begin
        tmr_restart = mid;
        if (mid) state_nxt = s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (mid && last_bit) state_nxt = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (mid) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (mid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      stage      <= '0;
      q          <= '0;
      par_ok     <= 1'b0;
      gap_armed  <= 1'b0;
      gap_cnt    <= '0;
      q_rdy      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      msg_end    <= 1'b0;
    end else begin
      state      <= state_nxt;
      q_rdy      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      msg_end    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clk_en) begin
            if (!d) begin
              gap_cnt <= '0;
            end else if (gap_armed) begin
              if (gap_cnt == 8'(MSG_GAP - 1)) begin
                msg_end   <= 1'b1;
                gap_armed <= 1'b0;
                gap_cnt   <= '0;
              end else begin
                gap_cnt <= gap_cnt + 8'd1;
              end
            end
          end
        end
        S_START: begin
          if (mid) par_ok <= 1'b1;
        end
        S_DATA: begin
          if (mid) begin
            for (int i = 0; i < DATA_W; i++) begin
              if (pos == BW'(i)) stage[i] <= s;
            end
          end
        end
        S_PARITY: begin
          if (mid) par_ok <= (s == par_calc(16'(stage), PARITY));
        end
        S_STOP: begin
          // Finish mid-stop-bit so a start edge right after the stop bit is not missed.
          if (mid) begin
            q          <= stage;
            q_rdy      <= s & par_ok;
            parity_err <= ~par_ok;
            frame_err  <= ~s;
            gap_armed  <= 1'b1;
            gap_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hsi_frame_rx.md
Name: hsi_frame_rx

Overview:
- Parametrised next-generation HSI serial frame receiver: one start bit, DATA_W data bits, an optional parity bit, and one stop bit, oversampled OSR times per bit on clk_en ticks.
- Adds start-bit glitch rejection, mid-bit sampling, selectable parity mode and bit order, and separate parity and framing error flags.
- Keeps the message-end (idle gap) indication.
- Sits between the line synchroniser and the HSI message assembler.

Parameters:
- DATA_W, 8: data bits per frame (1..16).
- OSR, 8: clk_en ticks per bit (4..32, even).
- PARITY, 1: 0 = none, 1 = odd (parity bit = ~^data), 2 = even (parity bit = ^data).
- MSB_FIRST, 0: 0 = LSB received first, 1 = MSB received first.
- MSG_GAP, 6: consecutive high ticks after a frame that signal message end (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- clk_en  in  1  oversampling tick; all state advances only when high.
- d  in  1  synchronised serial line; idle = 1.
- q  out  DATA_W  received data word; holds until the next frame completes.
- q_rdy  out  1  one-clk pulse: frame received with no error.
- parity_err  out  1  one-clk pulse: parity mismatch; q is still updated.
- frame_err  out  1  one-clk pulse: stop bit sampled 0.
- busy  out  1  high in every state except IDLE.
- msg_end  out  1  one-clk pulse: idle gap reached after a frame.

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=IDLE; all counters 0; q=0.
  - q_rdy, parity_err, frame_err, msg_end, busy = 0.
  - gap_armed = 0.
  - Reset mid-frame aborts the frame with no pulses.
- Nothing advances while clk_en=0. Output pulses last exactly one clk cycle, on the clk_en cycle of the event.
- IDLE:
  - On a tick with d=0: go to START, tick_cnt=0.
  - On a tick with d=1 and gap_armed=1: increment gap_cnt. When gap_cnt reaches MSG_GAP, pulse msg_end, then clear gap_armed and gap_cnt.
  - On a tick with d=0: also clear gap_cnt.
- START:
  - At tick_cnt = OSR/2-1, sample d.
  - d=1: glitch; return to IDLE with no outputs and gap_armed unchanged.
  - d=0: go to DATA with bit_idx=0 and tick_cnt=0.
- DATA:
  - Sample at tick_cnt = OSR-1, which is the mid-bit point.
  - Store at bit position bit_idx (MSB_FIRST=0) or DATA_W-1-bit_idx (MSB_FIRST=1) in a shift/staging register.
  - After bit_idx = DATA_W-1: go to PARITY if PARITY != 0, else STOP.
- PARITY: sample at mid-bit. parity_ok = (sample == expected per PARITY).
- STOP:
  - Sample at mid-bit, then load q from the staging register.
  - stop=1 and parity_ok: pulse q_rdy.
  - stop=1 and not parity_ok: pulse parity_err.
  - stop=0: pulse frame_err, plus parity_err if parity also failed. q_rdy stays low.
  - Then: state=IDLE, gap_armed=1, gap_cnt=0.
  - Completion is mid-stop-bit, so a following start edge is caught.
- Latency: completion pulse at (DATA_W + (PARITY?1:0) + 1)·OSR + OSR/2 ticks after the tick that detected the start edge. Defaults: 84 ticks.
- Width rules:
  - tick_cnt width = $clog2(OSR); wraps to 0 on each bit boundary.
  - bit_idx width = $clog2(DATA_W+1).
  - gap_cnt saturates at MSG_GAP.
- A new start edge during the gap: cancel the gap count (gap_armed stays 1) and begin a frame. msg_end is then pending after that frame.

Optional Feature:
- Macro HSI_RX_MAJORITY_EN.
- Defined: each sample point (start check, data, parity, stop) is the 2-of-3 majority of d at ticks mid-1, mid, mid+1. The decision is taken at tick mid+1, so all pulses shift one tick later. Requires OSR ≥ 4.
- Undefined: single sample at the mid tick, as above.

Decomposition:
- Package hsi_rx_pkg:
  - state enum IDLE/START/DATA/PARITY/STOP.
  - Parity-mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - Helper function par_calc(data, mode).
- Sub-module hsi_rx_bit_timer:
  - Owns tick_cnt and bit_idx.
  - Outputs a mid-bit strobe and a last_bit flag; restarted by the FSM.
- The FSM, staging register and gap counter stay in the top module.

Test Plan:
- Defaults, LSB-first frame 0xA5, parity bit 1, stop 1 -> q=0xA5, single q_rdy at tick 84 after the start edge, no errors.
- Defaults, frame 0x3C with parity bit deliberately inverted -> parity_err pulse, q=0x3C, q_rdy=0.
- MSB_FIRST=1, DATA_W=12, PARITY=0, line bits 1,0,1,1,0,0,0,0,1,1,1,1 -> q=0xB0F, q_rdy pulse.
- Stop bit forced 0 -> frame_err pulse; then line held high 6 ticks -> msg_end at the 6th tick; a 2-tick low glitch in IDLE -> no busy beyond START, no outputs.
- Two back-to-back frames 0x01, 0xFF with the second start edge immediately after the stop bit -> two q_rdy, msg_end only after the second frame; rst asserted mid-DATA -> all outputs 0, state IDLE.
- HSI_RX_MAJORITY_EN defined, 1-tick inverted spike at each data mid-bit of 0x55 -> q=0x55, q_rdy one tick later than without the macro.
